rpn_stack_master: RTL

//  Reverse-Polish expression evaluator that drives an external 4-bit LIFO through its push/pop interface.
//  - Accepts a token stream (operand / operator / END / CLEAR) over a valid/ready handshake.
//  - Tracks stack depth itself and reports results and errors.
//  - Sits between a token source (keypad/UART decoder) and the lab stack block.

---
 rtl/rpn_pkg.sv | 34 +++
 rtl/rpn_alu.sv | 32 +++
 rtl/rpn_stack_master.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rpn_pkg.sv
// Shared constants for the RPN evaluator: token kinds, opcodes,
// error codes and the controller state encoding.
package rpn_pkg;

    localparam logic [1:0] K_OPND  = 2'b00;
    localparam logic [1:0] K_OPER  = 2'b01;
    localparam logic [1:0] K_END   = 2'b10;
    localparam logic [1:0] K_CLEAR = 2'b11;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    localparam logic [1:0] E_NONE = 2'b00;
    localparam logic [1:0] E_OVF  = 2'b01;
    localparam logic [1:0] E_UNF  = 2'b10;
    localparam logic [1:0] E_ILL  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PUSH     = 4'd1,
        S_POP_B    = 4'd2,
        S_POP_A    = 4'd3,
        S_CAP_A    = 4'd4,
        S_PUSH_RES = 4'd5,
        S_POP_R    = 4'd6,
        S_CAP_R    = 4'd7,
        S_DRAIN    = 4'd8
    } state_t;

endpackage

// File: rtl/rpn_alu.sv
// Combinational operator unit: A op B modulo 2^DW plus illegal-op flag.
// Op 101 is MUL only when RPN_MUL_EN is defined, otherwise illegal.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [2:0]    i_op,
    output logic [DW-1:0] o_res,
    output logic          o_ill
);

    // Decode the opcode; anything not listed is flagged illegal
    always_comb begin
        o_res = '0;
        o_ill = 1'b0;
        case (i_op)
            OP_ADD: o_res = i_a + i_b;
            OP_SUB: o_res = i_a - i_b;
            OP_AND: o_res = i_a & i_b;
            OP_OR:  o_res = i_a | i_b;
            OP_XOR: o_res = i_a ^ i_b;
`ifdef RPN_MUL_EN
            OP_MUL: o_res = i_a * i_b;
`endif
            default: o_ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/rpn_stack_master.sv
// RPN evaluator driving an external LIFO through push/pop strobes.
// Optional RPN_MUL_EN enables the MUL operator (op 101).
module rpn_stack_master
    import rpn_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 4,
    localparam int AW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          tok_valid,
    output logic          tok_ready,
    input  logic [1:0]    tok_kind,
    input  logic [DW-1:0] tok_val,
    input  logic [2:0]    tok_op,
    output logic          st_push,
    output logic          st_pop,
    output logic [DW-1:0] st_data_wr,
    input  logic [DW-1:0] st_data_rd,
    output logic [AW-1:0] depth,
    output logic [DW-1:0] result,
    output logic          result_valid,
    output logic          err,
    output logic [1:0]    err_code
);

    state_t        r_state;
    state_t        w_nstate;
    logic [AW-1:0] r_depth;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [2:0]    r_op;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_result;
    logic          r_rv;
    logic          r_err;
    logic [1:0]    r_code;

    logic          w_push;
    logic          w_pop;
    logic          w_ready;
    logic [2:0]    w_alu_op;
    logic [DW-1:0] w_alu_res;
    logic          w_ill;
    logic          w_full;
    logic          w_empty;
    logic          w_lt2;

    assign w_full  = (r_depth == AW'(DEPTH));
    assign w_empty = (r_depth == '0);
    assign w_lt2   = (r_depth < AW'(2));

    // In IDLE the ALU screens the incoming opcode; later it computes
    assign w_alu_op = (r_state == S_IDLE) ? tok_op : r_op;

    rpn_alu #(.DW(DW)) u_alu (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_op  (w_alu_op),
        .o_res (w_alu_res),
        .o_ill (w_ill)
    );

    // Next-state and strobe decode
    always_comb begin
        w_nstate = r_state;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (tok_valid) begin
                    case (tok_kind)
                        K_CLEAR: if (!w_empty) w_nstate = S_DRAIN;
                        K_OPND:  if (!r_err && !w_full) w_nstate = S_PUSH;
                        K_OPER:  if (!r_err && !w_lt2 && !w_ill) w_nstate = S_POP_B;
                        default: if (!r_err && !w_empty) w_nstate = S_POP_R;
                    endcase
                end
            end
            S_PUSH: begin
                w_push   = 1'b1;
                w_nstate = S_IDLE;
            end
            S_POP_B: begin
                w_pop    = 1'b1;
                w_nstate = S_POP_A;
            end
            S_POP_A: begin
                w_pop    = 1'b1;
                w_nstate = S_CAP_A;
            end
            S_CAP_A:    w_nstate = S_PUSH_RES;
            S_PUSH_RES: begin
                w_push   = 1'b1;
                w_nstate = S_IDLE;
            end
            S_POP_R: begin
                w_pop    = 1'b1;
                w_nstate = S_CAP_R;
            end
            S_CAP_R:    w_nstate = S_IDLE;
            S_DRAIN: begin
                w_pop = 1'b1;
                if (r_depth == AW'(1)) w_nstate = S_IDLE;
            end
            default:    w_nstate = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_state <= S_IDLE;
        else       r_state <= w_nstate;
    end

    // Occupancy tracks every strobe issued to the LIFO
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)       r_depth <= '0;
        else if (w_push) r_depth <= r_depth + AW'(1);
        else if (w_pop)  r_depth <= r_depth - AW'(1);
    end

    // Operand capture, result capture and sticky first-error tracking
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_wdata  <= '0;
            r_result <= '0;
            r_rv     <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= E_NONE;
        end else begin
            r_rv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tok_valid) begin
                        if (tok_kind == K_CLEAR) begin
                            if (w_empty) begin
                                r_err  <= 1'b0;
                                r_code <= E_NONE;
                            end
                        end else if (!r_err) begin
                            case (tok_kind)
                                K_OPND: begin
                                    if (w_full) begin
                                        r_err  <= 1'b1;
                                        r_code <= E_OVF;
                                    end else begin
                                        r_wdata <= tok_val;
                                    end
                                end
                                K_OPER: begin
                                    if (w_lt2) begin
                                        r_err  <= 1'b1;
                                        r_code <= E_UNF;
                                    end else if (w_ill) begin
                                        r_err  <= 1'b1;
                                        r_code <= E_ILL;
                                    end else begin
                                        r_op <= tok_op;
                                    end
                                end
                                default: begin
                                    if (w_empty) begin
                                        r_err  <= 1'b1;
                                        r_code <= E_UNF;
                                    end
                                end
                            endcase
                        end
                    end
                end
                S_POP_A: r_b <= st_data_rd;
                S_CAP_A: r_a <= st_data_rd;
                S_CAP_R: begin
                    r_result <= st_data_rd;
                    r_rv     <= 1'b1;
                end
                S_DRAIN: begin
                    if (r_depth == AW'(1)) begin
                        r_err  <= 1'b0;
                        r_code <= E_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tok_ready    = w_ready;
    assign st_push      = w_push;
    assign st_pop       = w_pop;
    assign st_data_wr   = (r_state == S_PUSH_RES) ? w_alu_res : r_wdata;
    assign depth        = r_depth;
    assign result       = r_result;
    assign result_valid = r_rv;
    assign err          = r_err;
    assign err_code     = r_code;

endmodule
